// File: rtl/memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | memory : word-organised single-port data memory, byte-lane writes,       |
// |          one-cycle registered read data and ready.   Rev 1.0             |
// +--------------------------------------------------------------------------+
module memory #(
  parameter int DEPTH_WORDS   = 256,
  parameter int ADDR_LSB_BITS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  byte_enable,
  output logic [31:0] read_data,
  output logic        ready
);

  localparam int c_IDX_HI = ADDR_LSB_BITS + 1;
  localparam int c_TAG_LO = ADDR_LSB_BITS + 2;

  logic [31:0]              r_mem [DEPTH_WORDS];
  logic [ADDR_LSB_BITS-1:0] w_index;
  logic                     w_in_range;

  assign w_index    = addr[c_IDX_HI:2];
  assign w_in_range = (addr[31:c_TAG_LO] == '0);

  // Whole array clears on reset so a read can never return uninitialised data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < DEPTH_WORDS; w++) begin
        r_mem[w] <= '0;
      end
    end else if (mem_write && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_enable[i]) begin
          r_mem[w_index][8*i +: 8] <= write_data[8*i +: 8];
        end
      end
    end
  end

  // Same-edge read samples the array before the write lands (read-before-write).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data <= '0;
      ready     <= 1'b0;
    end else begin
      ready <= mem_read | mem_write;
      if (mem_read) begin
        read_data <= w_in_range ? r_mem[w_index] : 32'h0000_0000;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_memory : directed + randomized checks of memory against a word-array  |
// |             reference model.   Rev 1.0                                   |
// +--------------------------------------------------------------------------+
module tb_memory;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  byte_enable;
  logic [31:0] read_data;
  logic        ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model [256];
  logic [31:0] last_rd;

  memory dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .addr        (addr),
    .write_data  (write_data),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .byte_enable (byte_enable),
    .read_data   (read_data),
    .ready       (ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a >= 32'h400) return 32'h0;
    return model[a / 4 % 256];
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] mask;
    if (a >= 32'h400) return;
    mask = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
    model[a / 4 % 256] = (model[a / 4 % 256] & ~mask) | (d & mask);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int w = 0; w < 256; w++) model[w] = 32'h0;
    last_rd = 32'h0;
  endtask

  // One request cycle: drive at negedge, check outputs 1ns after the next rising edge.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input string tag);
    logic [31:0] exp_rd;
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; write_data = d; byte_enable = be;
    exp_rd = rd ? model_read(a) : last_rd;
    if (wr) model_write(a, d, be);
    @(posedge clk); #1;
    check({tag, "_ready"}, {31'h0, ready}, {31'h0, rd | wr});
    check({tag, "_data"}, read_data, exp_rd);
    last_rd = exp_rd;
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    addr = $urandom(); write_data = $urandom(); byte_enable = 4'($urandom());
    @(posedge clk); #1;
    check({tag, "_ready"}, {31'h0, ready}, 32'h0);
    check({tag, "_hold"}, read_data, last_rd);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    access(1'b0, 1'b1, a, d, be, "wr");
  endtask

  task automatic rd(input logic [31:0] a, input string tag);
    access(1'b1, 1'b0, a, 32'h0, 4'h0, tag);
  endtask

  initial begin
    logic [31:0] a;
    bit          r, w;
    reset_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    addr = '0; write_data = '0; byte_enable = '0;
    clear_model();
    #1;
    check("reset_ready", {31'h0, ready}, 32'h0);
    check("reset_data", read_data, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reset contents
    rd(32'h000, "rd_0x000");
    rd(32'h100, "rd_0x100");
    idle("idle0");

    // Full-word writes and overwrite
    wr(32'h00, 32'h1234_5678, 4'hF);
    wr(32'h04, 32'hDEAD_BEEF, 4'hF);
    rd(32'h00, "rd_0x00");
    check("lit_0x00", last_rd, 32'h1234_5678);
    rd(32'h04, "rd_0x04");
    check("lit_0x04", last_rd, 32'hDEAD_BEEF);
    wr(32'h00, 32'h4E45_5756, 4'hF);
    rd(32'h00, "rd_0x00_ow");
    check("lit_0x00_ow", last_rd, 32'h4E45_5756);

    // Byte-lane merges
    wr(32'h08, 32'h0, 4'hF);
    wr(32'h08, 32'hAABB_CCDD, 4'b0001);
    rd(32'h08, "be0001");
    check("lit_be0001", last_rd, 32'h0000_00DD);
    wr(32'h08, 32'hAABB_CCDD, 4'b0010);
    rd(32'h08, "be0010");
    check("lit_be0010", last_rd, 32'h0000_CCDD);
    wr(32'h08, 32'hAABB_CCDD, 4'b1100);
    rd(32'h08, "be1100");
    check("lit_be1100", last_rd, 32'hAABB_CCDD);
    wr(32'h08, 32'h5555_5555, 4'b0000);
    rd(32'h08, "be0000");
    wr(32'h50, 32'hFF00_0000, 4'b1000);
    rd(32'h50, "be1000");
    wr(32'h50, 32'h00FF_0000, 4'b0100);
    rd(32'h50, "be0100");
    check("lit_be0100", last_rd, 32'hFFFF_0000);

    // Alignment and independent words
    wr(32'h40, 32'hABCD_EF00, 4'hF);
    for (int k = 0; k < 4; k++) rd(32'h40 + k, "rd_align");
    check("lit_align", last_rd, 32'hABCD_EF00);
    wr(32'h10, 32'h1111_1111, 4'hF);
    wr(32'h20, 32'h2222_2222, 4'hF);
    wr(32'h30, 32'h3333_3333, 4'hF);
    rd(32'h10, "rd_0x10");
    rd(32'h20, "rd_0x20");
    rd(32'h30, "rd_0x30");

    // Boundaries
    wr(32'h3FC, 32'hFFFF_FFFF, 4'hF);
    rd(32'h3FC, "rd_0x3FC");
    check("lit_0x3FC", last_rd, 32'hFFFF_FFFF);
    wr(32'h400, 32'hCAFE_F00D, 4'hF);
    rd(32'h400, "rd_0x400");
    rd(32'h000, "rd_alias0");
    wr(32'h8000_0004, 32'h1357_9BDF, 4'hF);
    rd(32'h004, "rd_alias4");
    idle("idle1");

    // Simultaneous read+write: old data now, new data next read
    access(1'b1, 1'b1, 32'h40, 32'h0BAD_F00D, 4'hF, "rw_same");
    check("lit_rw_old", last_rd, 32'hABCD_EF00);
    rd(32'h40, "rw_next");
    check("lit_rw_new", last_rd, 32'h0BAD_F00D);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle("rnd_idle");
      end else begin
        a = 32'(($urandom_range(0, 15) * 4) + $urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) a = a + 32'h3C0;
        if ($urandom_range(0, 9) == 0) a = a | (32'h400 << $urandom_range(0, 21));
        r = 1'($urandom_range(0, 1));
        w = 1'($urandom_range(0, 1));
        if (!r && !w) r = 1'b1;
        access(r, w, a, $urandom(), 4'($urandom()), "rnd");
      end
    end

    // Asynchronous reset between edges while outputs are non-zero
    rd(32'h3FC, "pre_reset");
    check("lit_pre_reset", last_rd, model_read(32'h3FC));
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("mid_reset_ready", {31'h0, ready}, 32'h0);
    check("mid_reset_data", read_data, 32'h0);
    clear_model();
    @(negedge clk);
    reset_n = 1'b1;
    for (int w2 = 0; w2 < 256; w2++) rd(32'(w2 * 4), "post_reset");
    idle("idle_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
